// File: rtl/ticket_vend_ctrl_pkg.sv
// ticket_vend_ctrl_pkg
//   Shared definitions for the ticket vending controller: FSM state
//   encoding, coin values, ticket price table and the default idle
//   timeout in seconds.
package ticket_vend_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PAY      = 2'b01,
    ST_DISPENSE = 2'b10,
    ST_REFUND   = 2'b11
  } state_e;

  localparam int unsigned TIMEOUT_S_DEF = 10;

  localparam logic [4:0] COIN1_VAL  = 5'd1;
  localparam logic [4:0] COIN5_VAL  = 5'd5;
  localparam logic [4:0] COIN10_VAL = 5'd10;

  // Ticket type -> price in yuan.
  function automatic logic [3:0] price_lut(input logic [1:0] sel);
    logic [3:0] p;
    case (sel)
      2'b00:   p = 4'd3;
      2'b01:   p = 4'd5;
      2'b10:   p = 4'd8;
      default: p = 4'd12;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ticket_vend_ctrl_if.sv
// ticket_vend_ctrl_if
//   Bundles the vending controller's pulse inputs and registered
//   outputs.
//   master : drives sec_tick/start/sel_price/coins/cancel, observes outputs
//   slave  : the controller itself
interface ticket_vend_ctrl_if;
  logic       sec_tick;
  logic       start;
  logic [1:0] sel_price;
  logic       coin_1;
  logic       coin_5;
  logic       coin_10;
  logic       cancel;
  logic [4:0] paid;
  logic [3:0] price;
  logic [3:0] remain_s;
  logic       ticket_out;
  logic       change_out;
  logic [4:0] change_amt;
  logic [1:0] state;

  modport master (
    output sec_tick, start, sel_price, coin_1, coin_5, coin_10, cancel,
    input  paid, price, remain_s, ticket_out, change_out, change_amt, state
  );

  modport slave (
    input  sec_tick, start, sel_price, coin_1, coin_5, coin_10, cancel,
    output paid, price, remain_s, ticket_out, change_out, change_amt, state
  );
endinterface

// File: rtl/ticket_vend_ctrl_timer.sv
// timeout_timer
//   Seconds countdown for the payment phase.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : reload the count with TIMEOUT_S (wins over decrement)
//   en_i       : decrement allowed this cycle
//   tick_i     : one-second pulse
//   remain_o   : seconds left
//   zero_o     : this tick takes the count from 1 to 0 (combinational)
module timeout_timer #(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       en_i,
  input  logic       tick_i,
  output logic [3:0] remain_o,
  output logic       zero_o
);

  logic [3:0] remain_q, remain_d;

  always_comb begin
    remain_d = remain_q;
    if (load_i)
      remain_d = TIMEOUT_S[3:0];
    else if (en_i && tick_i && remain_q != 4'd0)
      remain_d = remain_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) remain_q <= 4'd0;
    else        remain_q <= remain_d;
  end

  assign remain_o = remain_q;
  // Depends only on the raw tick so the FSM can qualify it without a loop.
  assign zero_o   = tick_i && (remain_q == 4'd1);

endmodule

// File: rtl/ticket_vend_ctrl.sv
// ticket_vend_ctrl
//   Ticket vending FSM: IDLE -> PAY -> DISPENSE/REFUND -> IDLE.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of ticket_vend_ctrl_if (pulse inputs, all
//                outputs registered)
module ticket_vend_ctrl
  import ticket_vend_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = TIMEOUT_S_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  ticket_vend_ctrl_if.slave   bus
);

  state_e     state_q, state_d;
  logic [4:0] paid_q, paid_d;
  logic [3:0] price_q, price_d;
  logic       ticket_q, ticket_d;
  logic       chg_out_q, chg_out_d;
  logic [4:0] chg_amt_q, chg_amt_d;

  logic       tmr_load, tmr_en, tmr_zero;
  logic [3:0] remain;
  logic [4:0] coin_val, paid_sum;

  timeout_timer #(.TIMEOUT_S(TIMEOUT_S)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .tick_i   (bus.sec_tick),
    .remain_o (remain),
    .zero_o   (tmr_zero)
  );

  // Paid stays below price (<=11) while in PAY, so paid_sum <= 27 fits.
  assign coin_val = (bus.coin_1  ? COIN1_VAL  : 5'd0)
                  + (bus.coin_5  ? COIN5_VAL  : 5'd0)
                  + (bus.coin_10 ? COIN10_VAL : 5'd0);
  assign paid_sum = paid_q + coin_val;

  always_comb begin
    state_d   = state_q;
    paid_d    = paid_q;
    price_d   = price_q;
    ticket_d  = 1'b0;
    chg_out_d = 1'b0;
    chg_amt_d = chg_amt_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          price_d  = price_lut(bus.sel_price);
          paid_d   = 5'd0;
          tmr_load = 1'b1;
          state_d  = ST_PAY;
        end
      end
      ST_PAY: begin
        // Precedence: cancel > price reached > coin reload > tick.
        if (bus.cancel) begin
          paid_d = paid_sum;
          if (paid_sum != 5'd0) begin
            state_d   = ST_REFUND;
            chg_out_d = 1'b1;
            chg_amt_d = paid_sum;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (paid_sum >= {1'b0, price_q}) begin
          state_d   = ST_DISPENSE;
          paid_d    = paid_sum;
          ticket_d  = 1'b1;
          chg_amt_d = paid_sum - {1'b0, price_q};
          chg_out_d = (paid_sum > {1'b0, price_q});
        end else if (coin_val != 5'd0) begin
          paid_d   = paid_sum;
          tmr_load = 1'b1;
        end else if (bus.sec_tick) begin
          tmr_en = 1'b1;
          if (tmr_zero) begin
            if (paid_q != 5'd0) begin
              state_d   = ST_REFUND;
              chg_out_d = 1'b1;
              chg_amt_d = paid_q;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      // Pulses were raised on entry; just tidy up and return.
      ST_DISPENSE, ST_REFUND: begin
        paid_d  = 5'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      paid_q    <= 5'd0;
      price_q   <= 4'd0;
      ticket_q  <= 1'b0;
      chg_out_q <= 1'b0;
      chg_amt_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      paid_q    <= paid_d;
      price_q   <= price_d;
      ticket_q  <= ticket_d;
      chg_out_q <= chg_out_d;
      chg_amt_q <= chg_amt_d;
    end
  end

  assign bus.paid       = paid_q;
  assign bus.price      = price_q;
  assign bus.remain_s   = remain;
  assign bus.ticket_out = ticket_q;
  assign bus.change_out = chg_out_q;
  assign bus.change_amt = chg_amt_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
module tb_ticket_vend_ctrl;
  import ticket_vend_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ticket_vend_ctrl_if vif();

  ticket_vend_ctrl #(.TIMEOUT_S(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  typedef struct {
    logic       tkt;
    logic       chg;
    logic [4:0] amt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, act, exp);
  endtask

  task automatic push(input logic tkt, input logic chg, input logic [4:0] amt);
    exp_t e;
    e.tkt = tkt; e.chg = chg; e.amt = amt;
    sb_q.push_back(e);
  endtask

  // Apply one cycle of inputs starting at a negedge, then return to zero.
  task automatic drive(input logic st, input logic [1:0] sel, input logic c1,
                       input logic c5, input logic c10, input logic cn,
                       input logic tk);
    vif.start = st; vif.sel_price = sel; vif.coin_1 = c1; vif.coin_5 = c5;
    vif.coin_10 = c10; vif.cancel = cn; vif.sec_tick = tk;
    @(negedge clk);
    vif.start = 0; vif.coin_1 = 0; vif.coin_5 = 0; vif.coin_10 = 0;
    vif.cancel = 0; vif.sec_tick = 0;
  endtask

  task automatic do_start(input logic [1:0] sel);
    drive(1, sel, 0, 0, 0, 0, 0);
  endtask
  task automatic coin(input logic c1, input logic c5, input logic c10);
    drive(0, 2'b00, c1, c5, c10, 0, 0);
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) drive(0, 2'b00, 0, 0, 0, 0, 1);
  endtask

  // Scoreboard: every DISPENSE/REFUND cycle pops one expected outcome;
  // any other cycle must show no pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vif.state == ST_DISPENSE || vif.state == ST_REFUND) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_event", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ticket_out", int'(vif.ticket_out), int'(mon_e.tkt));
          chk("change_out", int'(vif.change_out), int'(mon_e.chg));
          chk("change_amt", int'(vif.change_amt), int'(mon_e.amt));
        end
      end else begin
        chk("no_pulse", int'({vif.ticket_out, vif.change_out}), 0);
      end
    end
  end

  initial begin
    vif.start = 0; vif.sel_price = 0; vif.coin_1 = 0; vif.coin_5 = 0;
    vif.coin_10 = 0; vif.cancel = 0; vif.sec_tick = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", int'(vif.state), int'(ST_IDLE));
    chk("rst_paid", int'(vif.paid), 0);
    chk("rst_price", int'(vif.price), 0);
    chk("rst_remain", int'(vif.remain_s), 0);
    chk("rst_tkt", int'(vif.ticket_out), 0);
    chk("rst_chg", int'(vif.change_out), 0);
    chk("rst_amt", int'(vif.change_amt), 0);
    rst_n = 1;
    @(negedge clk);

    // Coins ignored in IDLE
    coin(0, 0, 1);
    chk("idle_coin_paid", int'(vif.paid), 0);
    chk("idle_coin_state", int'(vif.state), int'(ST_IDLE));

    // Price 5, pay exactly 5
    do_start(2'b01);
    chk("s1_state", int'(vif.state), int'(ST_PAY));
    chk("s1_price", int'(vif.price), 5);
    chk("s1_remain", int'(vif.remain_s), 10);
    push(1, 0, 5'd0);
    coin(0, 1, 0);
    @(negedge clk);
    chk("s1_idle", int'(vif.state), int'(ST_IDLE));
    chk("s1_paid_clr", int'(vif.paid), 0);

    // Price 3, pay 10 -> change 7
    do_start(2'b00);
    push(1, 1, 5'd7);
    coin(0, 0, 1);
    @(negedge clk);
    chk("s2_amt_held", int'(vif.change_amt), 7);

    // Price 12: ticks, then 1+10 reloads timer, then 1 more -> exact
    do_start(2'b11);
    tick(3);
    chk("s3_remain_dec", int'(vif.remain_s), 7);
    coin(1, 0, 1);
    chk("s3_paid", int'(vif.paid), 11);
    chk("s3_remain_rld", int'(vif.remain_s), 10);
    push(1, 0, 5'd0);
    coin(1, 0, 0);
    @(negedge clk);

    // Price 8, pay 5, time out -> refund 5
    do_start(2'b10);
    coin(0, 1, 0);
    tick(9);
    chk("s4_remain_1", int'(vif.remain_s), 1);
    chk("s4_still_pay", int'(vif.state), int'(ST_PAY));
    push(0, 1, 5'd5);
    tick(1);
    @(negedge clk);
    chk("s4_idle", int'(vif.state), int'(ST_IDLE));
    chk("s4_amt_held", int'(vif.change_amt), 5);

    // Price 8, pay 5, cancel + coin_5 -> refund 10 (cancel beats price)
    do_start(2'b10);
    coin(0, 1, 0);
    push(0, 1, 5'd10);
    drive(0, 2'b00, 0, 1, 0, 1, 0);
    @(negedge clk);

    // start in PAY ignored; timeout with nothing paid -> IDLE silently
    do_start(2'b00);
    do_start(2'b11);
    chk("s6_price_kept", int'(vif.price), 3);
    chk("s6_state", int'(vif.state), int'(ST_PAY));
    tick(10);
    chk("s6_timeout_idle", int'(vif.state), int'(ST_IDLE));

    // Cancel with nothing paid -> IDLE silently
    do_start(2'b01);
    drive(0, 2'b00, 0, 0, 0, 1, 0);
    chk("s7_cancel_idle", int'(vif.state), int'(ST_IDLE));

    // Max paid: 11 then all three coins -> 27, change 15
    do_start(2'b11);
    coin(1, 0, 1);
    push(1, 1, 5'd15);
    coin(1, 1, 1);
    chk("s8_paid_max", int'(vif.paid), 27);
    @(negedge clk);

    // Reset mid-purchase with paid 6
    do_start(2'b10);
    coin(1, 1, 0);
    chk("s9_paid", int'(vif.paid), 6);
    rst_n = 0;
    @(negedge clk);
    chk("s9_state", int'(vif.state), int'(ST_IDLE));
    chk("s9_paid0", int'(vif.paid), 0);
    chk("s9_price0", int'(vif.price), 0);
    chk("s9_remain0", int'(vif.remain_s), 0);
    chk("s9_chg0", int'(vif.change_out), 0);
    chk("s9_tkt0", int'(vif.ticket_out), 0);
    chk("s9_amt0", int'(vif.change_amt), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
